// File: rtl/vec_sum_activate.sv
// vec_sum_activate
//   Back end of the 4x4 vector-matrix product in the fixed-point XOR
//   network. Each of the 4 neurons sums its 4 signed fixed-point products
//   plus a bias using saturating adds, one add per cycle on a single shared
//   accumulator. The sum then goes through a selectable activation. All 4
//   results are published together with a one-cycle done pulse.
//
// Parameters
//   ACT   activation: 0 = identity, 1 = ReLU, 2 = hard sigmoid
//   FRAC  fractional bits of the signed 32-bit fixed-point format
//
// Ports
//   clk_i      rising-edge clock
//   reset_i    asynchronous active-high reset
//   start_i    run request, only looked at while idle
//   product_i  16 signed products; neuron j uses entries 4j..4j+3
//   bias_i     4 signed biases, one per neuron
//   out_o      4 activated neuron results, registered
//   done_o     one-cycle pulse marking out_o/ovf_o as freshly valid
//   busy_o     high while a run is in progress
//   ovf_o      some add in the last run saturated
module vec_sum_activate #(
  parameter int ACT  = 2,
  parameter int FRAC = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [15:0][31:0] product_i,
  input  logic [3:0][31:0]  bias_i,
  output logic [3:0][31:0]  out_o,
  output logic              done_o,
  output logic              busy_o,
  output logic              ovf_o
);

  typedef enum logic [1:0] {IDLE, ACC, ACTIVATE} state_t;

  localparam logic signed [31:0] HALF = 32'sd1 <<< (FRAC - 1);
  localparam logic signed [31:0] ONE  = 32'sd1 <<< FRAC;

  state_t            state_q, state_d;
  logic [15:0][31:0] capProd_q, capProd_d;
  logic [3:0][31:0]  capBias_q, capBias_d;
  logic [31:0]       acc_q, acc_d;
  logic [2:0][31:0]  res_q, res_d;
  logic [3:0][31:0]  out_q, out_d;
  logic [1:0]        j_q, j_d;
  logic [1:0]        k_q, k_d;
  logic              ovfInt_q, ovfInt_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic [31:0]       addBase;
  logic [32:0]       addRes;

  // Saturating signed add. Bit 32 of the result flags saturation.
  function automatic logic [32:0] satAdd(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {a[31], a} + {b[31], b};
    if (s[32] != s[31])
      return {1'b1, (s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF)};
    return {1'b0, s[31:0]};
  endfunction

  // Activation. The hard sigmoid is 0.5 + x/4 clamped to [0, 1.0].
  // x>>>2 cannot push 0.5 + x/4 past 32 bits, so only the clamp is needed.
  function automatic logic [31:0] activate(input logic [31:0] x);
    logic signed [31:0] xs;
    logic signed [31:0] t;
    xs = x;
    t  = HALF + (xs >>> 2);
    if (ACT == 1)
      return xs[31] ? 32'd0 : x;
    if (ACT == 2) begin
      if (t < 0)   return 32'd0;
      if (t > ONE) return ONE;
      return t;
    end
    return x;
  endfunction

  // The first add of a neuron starts from its bias. Later adds start from
  // the running sum.
  always_comb begin
    addBase = (k_q == 2'd0) ? capBias_q[j_q] : acc_q;
    addRes  = satAdd(addBase, capProd_q[{j_q, k_q}]);
  end

  // Next-state and datapath. out only changes on the final activate step,
  // so a run aborted by reset never leaves a partial result behind.
  always_comb begin
    state_d   = state_q;
    capProd_d = capProd_q;
    capBias_d = capBias_q;
    acc_d     = acc_q;
    res_d     = res_q;
    out_d     = out_q;
    j_d       = j_q;
    k_d       = k_q;
    ovfInt_d  = ovfInt_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          capProd_d = product_i;
          capBias_d = bias_i;
          ovfInt_d  = 1'b0;
          j_d       = 2'd0;
          k_d       = 2'd0;
          busy_d    = 1'b1;
          state_d   = ACC;
        end
      end
      ACC: begin
        acc_d = addRes[31:0];
        if (addRes[32])
          ovfInt_d = 1'b1;
        k_d = k_q + 2'd1;
        if (k_q == 2'd3)
          state_d = ACTIVATE;
      end
      ACTIVATE: begin
        if (j_q != 2'd3) begin
          res_d[j_q] = activate(acc_q);
          j_d        = j_q + 2'd1;
          k_d        = 2'd0;
          state_d    = ACC;
        end else begin
          out_d   = {activate(acc_q), res_q};
          done_d  = 1'b1;
          ovf_d   = ovfInt_q;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      capProd_q <= '0;
      capBias_q <= '0;
      acc_q     <= '0;
      res_q     <= '0;
      out_q     <= '0;
      j_q       <= '0;
      k_q       <= '0;
      ovfInt_q  <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      capProd_q <= capProd_d;
      capBias_q <= capBias_d;
      acc_q     <= acc_d;
      res_q     <= res_d;
      out_q     <= out_d;
      j_q       <= j_d;
      k_q       <= k_d;
      ovfInt_q  <= ovfInt_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign out_o  = out_q;
  assign done_o = done_q;
  assign busy_o = busy_q;
  assign ovf_o  = ovf_q;

endmodule

// File: doc/vec_sum_activate.md
Name: vec_sum_activate

Overview:
- Downstream stage of the 4x4 vector-matrix product block in the fixed-point XOR network.
- Consumes the 16 Q16.16 partial products and, for each of 4 neurons, reduces 4 products plus a bias with saturating adds.
- Applies a selectable activation and presents 4 neuron outputs with a start/done handshake.
- Sequential: one saturating add per cycle, one shared accumulator.

Parameters:
- ACT, 2, activation select: 0 = identity, 1 = ReLU, 2 = hard sigmoid.
- FRAC, 16, fractional bits of the signed 32-bit fixed-point format. Constants below are given for FRAC=16.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- product  input  32 x [15:0]  signed Q16.16 products; neuron j uses product[4j+0..4j+3]
- bias  input  32 x [3:0]  signed Q16.16 bias per neuron
- out  output  32 x [3:0]  activated neuron results, registered
- done  output  1  one-cycle pulse; out is valid when it is high
- busy  output  1  high while a run is in progress
- ovf  output  1  sticky per run: any add saturated; valid with done

Behaviour:
- Reset (async, active-high): state=IDLE; out[*]=0, done=0, busy=0, ovf=0; accumulator and captured inputs cleared. Reset mid-run aborts the run with no partial update of out.
- States: IDLE, ACC, ACT.
- IDLE: if start=1 at edge E0, capture product[15:0] and bias[3:0] into internal registers, clear ovf_int, set j=0, k=0, busy=1, go to ACC. Inputs may change after E0.
- ACC, edge per k=0..3: acc = sat(base + cap_product[4j+k]), where base = cap_bias[j] for k=0 and acc otherwise. The add is 33-bit signed; the result saturates to [0x80000000, 0x7FFFFFFF], and ovf_int is set on saturation. After k=3, go to ACT.
- ACT, one edge: res[j] = f(acc).
  - If j<3: j=j+1, k=0, go to ACC.
  - If j=3: copy res[0..2] and f(acc) to out in the same edge, set done=1, ovf=ovf_int, busy=0, go to IDLE.
- Timing: neuron j finishes at edge E(5j+5). out and done update at E20, so latency is 20 cycles from the start edge. done clears at E21.
- out holds its previous values for the whole run and updates atomically at E20.
- f, ACT=0: y = x.
- f, ACT=1: y = (x<0) ? 0 : x.
- f, ACT=2: y = 0x00008000 + (x >>> 2) (arithmetic shift), clamped to [0x00000000, 0x00010000]. This cannot overflow 32 bits. The clamp does not set ovf.
- start while busy (ACC/ACT): ignored, no effect on the run.
- start high in the cycle done is high (state IDLE): accepted at E21 as a new run. done still falls at E21, and busy rises at E21.
- start held high continuously: runs back to back, with one IDLE cycle between runs.
- ovf holds its value until the next done or reset.

Test Plan:
1. ACT=0, all product=0x00010000, bias=0, start at E0 -> done only at E20. out[0..3]=0x00040000, ovf=0, busy high E1..E20.
2. ACT=2 with per-neuron sums 0, +4.0, -4.0, +1.0 -> out = 0x00008000, 0x00010000, 0x00000000, 0x0000C000.
3. ACT=0, product[0..3]=0x7FFF0000, bias[0]=0x7FFF0000 -> out[0]=0x7FFFFFFF, ovf=1. Then product[4..7]=0x80000000, bias[1]=0xFFFF0000 -> out[1]=0x80000000.
4. ACT=1, products=0x00010000, bias=0xFFFE0000 (-2.0) -> out=0x00020000. A neuron with products=0xFFFF0000 -> out=0.
5. Toggle start at E5 and E12 -> no restart, done at E20 only. Start high during the done cycle -> second done at E41 with new captured values.
6. Assert reset at E10 -> out=0, busy=0, done=0 asynchronously. Release, then start -> normal results 20 cycles later; no stale accumulator contribution.
